led8_bar_arbiter: RTL and testbench

Shares the 8-LED bar between three pattern sources: one alarm source with absolute priority and two normal sources served round-robin in fixed time slices. Slice time comes from the board's 1 Hz square wave, edge-detected inside the block. The block sits between the counter/pattern generators and the `led` pins, replacing the direct counter-to-LED connection.

---
 rtl/led8_bar_arbiter_pkg.sv | 15 +
 rtl/led8_bar_arbiter_slow_clk_tick.sv | 18 +
 rtl/led8_bar_arbiter.sv | 94 +++++++++
 tb/tb_led8_bar_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led8_bar_arbiter_pkg.sv
// led8_bar_arbiter_pkg: shared state codes, requester indices, idle pattern and the normal-source swap helper
package led8_bar_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_ALARM = 2'd2
  } state_t;
  localparam int REQ_ALARM = 0;
  localparam int REQ_A = 1;
  localparam int REQ_B = 2;
  localparam logic [7:0] DEFAULT_IDLE_PATTERN = 8'h00;
  function automatic logic [1:0] other_src(input logic [1:0] k);
    return k == 2'd1 ? 2'd2 : 2'd1;
  endfunction
endpackage

// File: rtl/led8_bar_arbiter_slow_clk_tick.sv
// slow_clk_tick: 2-flop sync + rising-edge detect of slow (clk domain), registered one-cycle tick; ports clk, rst_n (async low), slow, tick
module slow_clk_tick (
  input  logic clk,
  input  logic rst_n,
  input  logic slow,
  output logic tick
);
  logic [2:0] sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 3'b000;
      tick <= 1'b0;
    end else begin
      sync <= {sync[1:0], slow};
      tick <= sync[1] & ~sync[2];
    end
  end
endmodule

// File: rtl/led8_bar_arbiter.sv
// led8_bar_arbiter: alarm-priority, round-robin LED bar sharing; ports fpga_clk, sys_init_ctrl_n (async low), clk_1Hz, req[2:0], pat0..2 -> gnt[2:0], led[7:0]
module led8_bar_arbiter
  import led8_bar_arbiter_pkg::*;
#(
  parameter int DWELL_TICKS = 4,
  parameter logic [7:0] IDLE_PATTERN = DEFAULT_IDLE_PATTERN,
  parameter bit BLINK_ALARM = 1'b1
) (
  input  logic       fpga_clk,
  input  logic       sys_init_ctrl_n,
  input  logic       clk_1Hz,
  input  logic [2:0] req,
  input  logic [7:0] pat0,
  input  logic [7:0] pat1,
  input  logic [7:0] pat2,
  output logic [2:0] gnt,
  output logic [7:0] led
);
  localparam logic [3:0] DWELL = 4'(DWELL_TICKS);
  state_t state, state_d;
  logic [1:0] rr, rr_d;
  logic [3:0] dwell, dwell_d;
  logic phase, phase_d, tick;
  logic [2:0] gnt_d;
  logic [7:0] led_d;

  slow_clk_tick u_tick (.clk(fpga_clk), .rst_n(sys_init_ctrl_n), .slow(clk_1Hz), .tick(tick));

  dwell_range: assert property (@(posedge fpga_clk) DWELL_TICKS >= 1 && DWELL_TICKS <= 15);

  always_ff @(posedge fpga_clk or negedge sys_init_ctrl_n) begin
    if (!sys_init_ctrl_n) begin
      state <= ST_IDLE;
      rr <= 2'd1;
      dwell <= 4'd0;
      phase <= 1'b1;
      gnt <= 3'b000;
      led <= IDLE_PATTERN;
    end else begin
      state <= state_d;
      rr <= rr_d;
      dwell <= dwell_d;
      phase <= phase_d;
      gnt <= gnt_d;
      led <= led_d;
    end
  end

  // While serving, rr always names the owner, so a preempted owner wins the next tie.
  always_comb begin
    state_d = state;
    rr_d = rr;
    dwell_d = dwell;
    phase_d = phase;
    case (state)
      ST_IDLE: begin
        if (req[REQ_ALARM]) begin
          state_d = ST_ALARM;
          phase_d = 1'b1;
        end else if (req[REQ_A] || req[REQ_B]) begin
          state_d = ST_SERVE;
          rr_d = req[REQ_A] && req[REQ_B] ? rr : req[REQ_A] ? 2'd1 : 2'd2;
          dwell_d = DWELL;
        end
      end
      ST_SERVE: begin
        if (req[REQ_ALARM]) begin
          state_d = ST_ALARM;
          phase_d = 1'b1;
        end else if (!req[rr]) begin
          state_d = ST_IDLE;
          rr_d = other_src(rr);
        end else if (tick) begin
          dwell_d = dwell - 4'd1;
          if (dwell <= 4'd1) begin
            dwell_d = DWELL;
            rr_d = req[other_src(rr)] ? other_src(rr) : rr;
          end
        end
      end
      ST_ALARM: begin
        if (!req[REQ_ALARM]) state_d = ST_IDLE;
        else if (tick && BLINK_ALARM) phase_d = ~phase;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d = state == ST_SERVE ? (rr == 2'd2 ? 3'b100 : 3'b010) : state == ST_ALARM ? 3'b001 : 3'b000;
    led_d = state == ST_SERVE ? (rr == 2'd2 ? pat2 : pat1) :
            state == ST_ALARM ? (phase || !BLINK_ALARM ? pat0 : 8'h00) : IDLE_PATTERN;
  end
endmodule

// File: tb/tb_led8_bar_arbiter.sv
// tb_led8_bar_arbiter: randomized and directed checks of led8_bar_arbiter against a behavioural model
module tb_led8_bar_arbiter;
  localparam int DW = 2;
  logic fpga_clk, rst_n, clk_1hz;
  logic [2:0] req, gnt;
  logic [7:0] pat0, pat1, pat2, led;
  int n_chk, n_fail;
  bit slow_en;
  int slow_half, slow_cnt;
  int m_st, m_own, m_rr, m_left, m_phase;
  logic [3:0] h;
  logic [2:0] exp_gnt;
  logic [7:0] exp_led;
  logic exp_tick;

  led8_bar_arbiter #(.DWELL_TICKS(DW), .IDLE_PATTERN(8'h00), .BLINK_ALARM(1'b1)) dut (
    .fpga_clk(fpga_clk), .sys_init_ctrl_n(rst_n), .clk_1Hz(clk_1hz), .req(req),
    .pat0(pat0), .pat1(pat1), .pat2(pat2), .gnt(gnt), .led(led)
  );

  initial begin
    fpga_clk = 1'b0;
    forever #5 fpga_clk = ~fpga_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_st = 0; m_own = 1; m_rr = 1; m_left = 0; m_phase = 1;
    h = 4'b0; exp_gnt = 3'b000; exp_led = 8'h00; exp_tick = 1'b0;
  endtask

  // m_st: 0 nothing granted, 1 a normal source owns the bar, 2 alarm showing.
  // h[0] is the newest clk_1hz sample; the arbiter sees a rise three edges late.
  task automatic model_step();
    logic t;
    int oth;
    t = h[2] & ~h[3];
    exp_tick = h[1] & ~h[2];
    exp_gnt = m_st == 1 ? 3'(1 << m_own) : m_st == 2 ? 3'b001 : 3'b000;
    exp_led = m_st == 1 ? (m_own == 1 ? pat1 : pat2) : m_st == 2 ? (m_phase != 0 ? pat0 : 8'h00) : 8'h00;
    oth = 3 - m_own;
    if (m_st == 0) begin
      if (req[0]) begin m_st = 2; m_phase = 1; end
      else if (req[1] || req[2]) begin
        m_own = (req[1] && req[2]) ? m_rr : (req[1] ? 1 : 2);
        m_rr = m_own; m_left = DW; m_st = 1;
      end
    end else if (m_st == 1) begin
      if (req[0]) begin m_st = 2; m_phase = 1; end
      else if (!req[m_own]) begin m_st = 0; m_rr = oth; end
      else if (t) begin
        m_left = m_left - 1;
        if (m_left <= 0) begin
          m_left = DW;
          if (req[oth]) begin m_own = oth; m_rr = oth; end
        end
      end
    end else begin
      if (!req[0]) m_st = 0;
      else if (t) m_phase = 1 - m_phase;
    end
    h = {h[2:0], clk_1hz};
  endtask

  task automatic cycle();
    @(posedge fpga_clk);
    if (rst_n) model_step(); else model_reset();
    #1;
    if (slow_en) begin
      slow_cnt++;
      if (slow_cnt >= slow_half) begin slow_cnt = 0; clk_1hz = ~clk_1hz; end
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    model_reset();
    clk_1hz = 1'b0;
    slow_cnt = 0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = 3'b000; pat0 = 8'h00; pat1 = 8'hAA; pat2 = 8'h55;
    reset_pulse();
    cycle();
    n_chk++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got=%b want=000", gnt); end
    n_chk++; if (led !== 8'h00) begin n_fail++; $display("FAIL reset_led got=%h want=00", led); end
    req = 3'b010;
    repeat (5) cycle();
    n_chk++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL pre_reset_gnt got=%b want=010", gnt); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (gnt !== 3'b000 || led !== 8'h00) begin n_fail++; $display("FAIL async_reset got gnt=%b led=%h want 000/00", gnt, led); end
    model_reset(); clk_1hz = 1'b0; slow_cnt = 0;
    cycle();
    rst_n = 1'b1;
    req = 3'b000;
  endtask

  task automatic test_tick();
    int cnt;
    reset_pulse();
    slow_en = 0; clk_1hz = 1'b0; req = 3'b000;
    repeat (4) cycle();
    clk_1hz = 1'b1;
    cycle(); cycle();
    n_chk++; if (dut.tick !== 1'b0) begin n_fail++; $display("FAIL tick_early got=%b want=0", dut.tick); end
    cycle();
    n_chk++; if (dut.tick !== 1'b1) begin n_fail++; $display("FAIL tick_at_3 got=%b want=1", dut.tick); end
    cnt = 0;
    repeat (40) begin
      cycle();
      if (dut.tick) cnt++;
      n_chk++; if (dut.tick !== exp_tick) begin n_fail++; $display("FAIL tick_model got=%b want=%b", dut.tick, exp_tick); end
    end
    n_chk++; if (cnt != 0) begin n_fail++; $display("FAIL tick_held got=%0d ticks want=0", cnt); end
    clk_1hz = 1'b0; slow_cnt = 0; slow_en = 1;
    repeat (100) begin
      cycle();
      n_chk++; if (dut.tick !== exp_tick) begin n_fail++; $display("FAIL tick_toggle got=%b want=%b", dut.tick, exp_tick); end
    end
  endtask

  task automatic test_rotation();
    int sw;
    logic [2:0] prev;
    slow_half = 8;
    reset_pulse();
    pat1 = 8'hAA; pat2 = 8'h55; req = 3'b110;
    cycle(); cycle();
    n_chk++; if (gnt !== 3'b010 || led !== 8'hAA) begin n_fail++; $display("FAIL rot_first got gnt=%b led=%h want 010/aa", gnt, led); end
    sw = 0; prev = gnt;
    repeat (300) begin
      cycle();
      n_chk++;
      if (gnt !== exp_gnt || led !== exp_led || dut.tick !== exp_tick) begin
        n_fail++; $display("FAIL rot_model got gnt=%b led=%h tick=%b want gnt=%b led=%h tick=%b", gnt, led, dut.tick, exp_gnt, exp_led, exp_tick);
      end
      n_chk++; if (gnt !== 3'b010 && gnt !== 3'b100) begin n_fail++; $display("FAIL rot_gap got=%b want 010 or 100", gnt); end
      if (gnt !== prev) sw++;
      prev = gnt;
    end
    n_chk++; if (sw < 7) begin n_fail++; $display("FAIL rot_switches got=%0d want>=7", sw); end
  endtask

  task automatic test_lone();
    reset_pulse();
    req = 3'b100;
    cycle(); cycle();
    repeat (170) begin
      cycle();
      n_chk++; if (gnt !== 3'b100 || led !== pat2) begin n_fail++; $display("FAIL lone got gnt=%b led=%h want 100/%h", gnt, led, pat2); end
      n_chk++; if (gnt !== exp_gnt || led !== exp_led) begin n_fail++; $display("FAIL lone_model got gnt=%b led=%h want %b/%h", gnt, led, exp_gnt, exp_led); end
    end
  endtask

  task automatic test_alarm();
    bit found;
    reset_pulse();
    pat0 = 8'hFF; pat1 = 8'hAA; req = 3'b010;
    repeat (3) cycle();
    n_chk++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL alarm_pre got=%b want=010", gnt); end
    req = 3'b011;
    cycle(); cycle();
    n_chk++; if (gnt !== 3'b001 || led !== 8'hFF) begin n_fail++; $display("FAIL alarm_entry got gnt=%b led=%h want 001/ff", gnt, led); end
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      n_chk++; if (gnt !== exp_gnt || led !== exp_led) begin n_fail++; $display("FAIL alarm_model got gnt=%b led=%h want %b/%h", gnt, led, exp_gnt, exp_led); end
      if (led === 8'h00) found = 1;
    end
    n_chk++; if (!found) begin n_fail++; $display("FAIL alarm_blink_off got led=%h want 00 within 40 cycles", led); end
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (led === 8'hFF) found = 1;
    end
    n_chk++; if (!found) begin n_fail++; $display("FAIL alarm_blink_on got led=%h want ff within 40 cycles", led); end
    req = 3'b110;
    cycle(); cycle();
    n_chk++; if (gnt !== 3'b000 || led !== 8'h00) begin n_fail++; $display("FAIL alarm_exit_idle got gnt=%b led=%h want 000/00", gnt, led); end
    cycle();
    n_chk++; if (gnt !== 3'b010 || led !== 8'hAA) begin n_fail++; $display("FAIL alarm_resume got gnt=%b led=%h want 010/aa", gnt, led); end
  endtask

  task automatic wait_expiry_edge(output bit ok);
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      cycle();
      n_chk++; if (gnt !== exp_gnt || led !== exp_led) begin n_fail++; $display("FAIL expiry_model got gnt=%b led=%h want %b/%h", gnt, led, exp_gnt, exp_led); end
      if (m_st == 1 && m_left == 1 && h[2] && !h[3]) ok = 1;
    end
  endtask

  task automatic test_same_cycle();
    bit ok;
    int own;
    reset_pulse();
    req = 3'b110;
    wait_expiry_edge(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL same_wait got=timeout want=expiry edge"); end
    own = m_own;
    req = 3'b111;
    cycle(); cycle();
    n_chk++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL same_alarm got=%b want=001", gnt); end
    req = 3'b110;
    cycle(); cycle();
    n_chk++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL same_idle got=%b want=000", gnt); end
    cycle();
    n_chk++; if (gnt !== 3'(1 << own)) begin n_fail++; $display("FAIL same_resume got=%b want=%b", gnt, 3'(1 << own)); end
  endtask

  task automatic test_release_expiry();
    bit ok;
    int own;
    reset_pulse();
    req = 3'b110;
    wait_expiry_edge(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rel_wait got=timeout want=expiry edge"); end
    own = m_own;
    req[own] = 1'b0;
    cycle(); cycle();
    n_chk++; if (gnt !== 3'b000 || led !== 8'h00) begin n_fail++; $display("FAIL rel_idle got gnt=%b led=%h want 000/00", gnt, led); end
    cycle();
    n_chk++; if (gnt !== 3'(1 << (3 - own))) begin n_fail++; $display("FAIL rel_other got=%b want=%b", gnt, 3'(1 << (3 - own))); end
  endtask

  task automatic test_random();
    int hold;
    reset_pulse();
    slow_half = $urandom_range(3, 10);
    hold = 0;
    repeat (3000) begin
      if (hold == 0) begin
        req = {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0};
        hold = $urandom_range(1, 40);
      end
      hold--;
      if ($urandom_range(0, 7) == 0) begin
        pat0 = 8'($urandom); pat1 = 8'($urandom); pat2 = 8'($urandom);
      end
      cycle();
      n_chk++;
      if (gnt !== exp_gnt || led !== exp_led || dut.tick !== exp_tick) begin
        n_fail++; $display("FAIL rand_model got gnt=%b led=%h tick=%b want gnt=%b led=%h tick=%b", gnt, led, dut.tick, exp_gnt, exp_led, exp_tick);
      end
      n_chk++; if ($countones(gnt) > 1) begin n_fail++; $display("FAIL rand_onehot got=%b want one-hot or zero", gnt); end
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 3'b000; pat0 = 8'h00; pat1 = 8'h00; pat2 = 8'h00; clk_1hz = 1'b0;
    slow_en = 1; slow_half = 8; slow_cnt = 0; n_chk = 0; n_fail = 0;
    model_reset();
    #1;
    test_reset();
    test_tick();
    test_rotation();
    test_lone();
    test_alarm();
    test_same_cycle();
    test_release_expiry();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
